// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready handshake, wait-state watchdog and sticky error flags.
// Define MULTICYCLE_JUMP_EN to build the JUMP state for opcode 0x02.
module multicycle_control #(
   parameter int ALU_OP_WIDTH   = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [5:0]              OP,
   input  logic                    mem_ready,
   output logic                    IorD,
   output logic                    MemRead,
   output logic                    MemWrite,
   output logic                    IRWrite,
   output logic                    PCWrite,
   output logic                    BranchEQ,
   output logic                    BranchNE,
   output logic [1:0]              PCSource,
   output logic                    RegDst,
   output logic                    MemtoReg,
   output logic                    RegWrite,
   output logic                    ALUSrcA,
   output logic [1:0]              ALUSrcB,
   output logic [ALU_OP_WIDTH-1:0] ALUOp,
   output logic [3:0]              state,
   output logic                    illegal_op,
   output logic                    bus_error
);

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
`ifdef MULTICYCLE_JUMP_EN
   localparam logic [5:0] OP_J    = 6'h02;
`endif

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_ANDI = 3'b011;
   localparam logic [2:0] ALU_LUI  = 3'b100;
   localparam logic [2:0] ALU_ORI  = 3'b101;
   localparam logic [2:0] ALU_ADDI = 3'b110;
   localparam logic [2:0] ALU_R    = 3'b111;

   localparam int              CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic             WD_EN    = (TIMEOUT_CYCLES > 0);

   typedef enum logic [3:0] {
      S_INIT      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXECUTE   = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_IMM_EXEC  = 4'd10,
`ifdef MULTICYCLE_JUMP_EN
      S_IMM_WB    = 4'd11,
      S_JUMP      = 4'd12
`else
      S_IMM_WB    = 4'd11
`endif
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  wait_cnt;
   logic              in_wait_state;
   logic              waiting;
   logic              expire;
   logic              set_illegal;
   logic              set_bus;
   logic [2:0]        alu_code;
   logic [2:0]        imm_alu_code;

   // A wait cycle is one spent in a memory state without mem_ready; expiry lands on the last allowed one.
   assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
   assign waiting       = in_wait_state && !mem_ready;
   assign expire        = WD_EN && waiting && (wait_cnt == CNT_LAST);

   always_comb begin
      imm_alu_code = ALU_ADD;
      case (OP)
         OP_ADDI: imm_alu_code = ALU_ADDI;
         OP_ANDI: imm_alu_code = ALU_ANDI;
         OP_ORI:  imm_alu_code = ALU_ORI;
         OP_LUI:  imm_alu_code = ALU_LUI;
         default: imm_alu_code = ALU_ADD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (WD_EN && waiting && !expire) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         illegal_op <= 1'b0;
         bus_error  <= 1'b0;
      end else begin
         if (set_illegal) illegal_op <= 1'b1;
         if (set_bus)     bus_error  <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      set_illegal = 1'b0;
      set_bus     = 1'b0;
      alu_code    = ALU_ADD;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      BranchEQ    = 1'b0;
      BranchNE    = 1'b0;
      PCSource    = 2'b00;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      case (state_q)
         S_INIT: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            ALUSrcB = 2'b01;
            if (expire) begin
               set_bus = 1'b1;
               state_d = S_FETCH;
            end else begin
               MemRead = 1'b1;
               if (mem_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  state_d = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (OP)
               OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
               OP_R:                             state_d = S_EXECUTE;
               OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IMM_EXEC;
`ifdef MULTICYCLE_JUMP_EN
               OP_J:                             state_d = S_JUMP;
`endif
               default: begin
                  state_d     = S_FETCH;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (OP == OP_LW)      state_d = S_MEM_READ;
            else if (OP == OP_SW) state_d = S_MEM_WRITE;
            else                  state_d = S_FETCH;
         end
         S_MEM_READ: begin
            IorD = 1'b1;
            if (expire) begin
               set_bus = 1'b1;
               state_d = S_FETCH;
            end else begin
               MemRead = 1'b1;
               if (mem_ready) state_d = S_MEM_WB;
            end
         end
         S_MEM_WB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEM_WRITE: begin
            IorD = 1'b1;
            if (expire) begin
               set_bus = 1'b1;
               state_d = S_FETCH;
            end else begin
               MemWrite = 1'b1;
               if (mem_ready) state_d = S_FETCH;
            end
         end
         S_EXECUTE: begin
            ALUSrcA  = 1'b1;
            alu_code = ALU_R;
            state_d  = S_R_WB;
         end
         S_R_WB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            alu_code = ALU_R;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            alu_code = ALU_SUB;
            PCSource = 2'b01;
            BranchEQ = (OP == OP_BEQ);
            BranchNE = (OP == OP_BNE);
            state_d  = S_FETCH;
         end
         S_IMM_EXEC: begin
            ALUSrcA  = 1'b1;
            ALUSrcB  = 2'b10;
            alu_code = imm_alu_code;
            state_d  = S_IMM_WB;
         end
         S_IMM_WB: begin
            RegWrite = 1'b1;
            alu_code = imm_alu_code;
            state_d  = S_FETCH;
         end
`ifdef MULTICYCLE_JUMP_EN
         S_JUMP: begin
            PCSource = 2'b10;
            PCWrite  = 1'b1;
            state_d  = S_FETCH;
         end
`endif
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   assign ALUOp = ALU_OP_WIDTH'(alu_code);
   assign state = state_q;

endmodule
